// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared types and constants for the instruction-memory boot loader.
//   boot_state_t : loader FSM states
//   BOOT_SYNC    : frame sync byte
//   LEN_W        : width of the frame word-count field
// -----------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } boot_state_t;

    localparam logic [7:0] BOOT_SYNC = 8'hA5;
    localparam int         LEN_W     = 16;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl_if
// Byte stream from the UART receiver and the instruction-memory write port.
//   rx_valid / rx_data : one-cycle byte strobe plus byte (no backpressure; a
//                        byte is consumed on every edge where rx_valid = 1)
//   imem_wr_en         : one-cycle write strobe; imem_wr_addr / imem_wr_data
//                        are valid in the same cycle
// Modports:
//   slave  : the loader (consumes rx, drives the memory write port)
//   master : the environment (UART side and memory side)
// -----------------------------------------------------------------------------
interface imem_boot_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [31:0]       imem_wr_data;

    modport slave (
        input  rx_valid, rx_data,
        output imem_wr_en, imem_wr_addr, imem_wr_data
    );

    modport master (
        output rx_valid, rx_data,
        input  imem_wr_en, imem_wr_addr, imem_wr_data
    );
endinterface

// File: rtl/boot_word_pack.sv
// -----------------------------------------------------------------------------
// boot_word_pack
// Packs four bytes (least-significant first) into a 32-bit word.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop any partial word and restart at byte 0
//   byte_valid  : byte_in is to be packed this cycle
//   byte_in     : incoming byte
//   word_valid  : combinational; high in the cycle the 4th byte is presented
//   word        : combinational; the completed word (valid with word_valid)
// -----------------------------------------------------------------------------
module boot_word_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] sr_q, sr_d;

    always_comb begin
        idx_d = idx_q;
        sr_d  = sr_q;
        if (clear) begin
            idx_d = 2'd0;
            sr_d  = 32'd0;
        end else if (byte_valid) begin
            idx_d = idx_q + 2'd1;
            // Right shift: after four bytes the first one sits in bits [7:0].
            sr_d  = {byte_in, sr_q[31:8]};
        end
    end

    // The word is presented combinationally alongside byte 4 so the
    // controller can register it on the very edge that accepts that byte.
    assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
    assign word       = {byte_in, sr_q[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            sr_q  <= 32'd0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
// Boot loader: parses a framed UART byte stream (A5, LEN_LO, LEN_HI, payload,
// optional CSUM), writes 32-bit little-endian words to instruction memory
// from address 0, and holds the CPU in reset until a valid image is loaded.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the CSUM byte, an 8-bit XOR
// over the payload; mismatch sends the loader to ERR).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_boot_ctrl_if.slave (rx byte strobe in, imem write out)
//   start      : re-arm from DONE or ERR (ignored elsewhere; wins over rx)
//   cpu_rst_n  : active-low CPU reset, released one cycle after DONE entry
//   boot_done  : image accepted
//   boot_err   : frame rejected
//   state_o    : current FSM state (debug)
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    imem_boot_ctrl_if.slave        bus,
    input  logic                   start,
    output logic                   cpu_rst_n,
    output logic                   boot_done,
    output logic                   boot_err,
    output boot_state_t            state_o
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t TAIL_ST = CSUM;
`else
    localparam boot_state_t TAIL_ST = DONE;
`endif

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_err_q, boot_err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [LEN_W-1:0]  len;
    logic              pack_clear;
    logic              pack_byte_valid;
    logic              word_valid;
    logic [31:0]       word;

    // The packer only runs while in DATA; any other state holds it empty,
    // so a new frame always starts at byte 0.
    assign pack_clear      = (state_q != DATA);
    assign pack_byte_valid = bus.rx_valid && (state_q == DATA);
    assign len             = {bus.rx_data, len_lo_q};

    boot_word_pack u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .byte_valid (pack_byte_valid),
        .byte_in    (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        len_lo_d  = len_lo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == BOOT_SYNC) begin
                    state_d = LEN_LO;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            LEN_LO: begin
                if (bus.rx_valid) begin
                    len_lo_d = bus.rx_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (bus.rx_valid) begin
                    addr_d = '0;
                    rem_d  = len;
                    if (len == '0)
                        state_d = TAIL_ST;
                    else if (32'(len) > DEPTH)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
`ifdef BOOT_CHECKSUM_EN
                if (bus.rx_valid)
                    csum_d = csum_q ^ bus.rx_data;
`endif
                if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = word;
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = TAIL_ST;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (bus.rx_valid)
                    state_d = (bus.rx_data == csum_q) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                // start takes priority; any byte in the same cycle is dropped.
                if (start)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        boot_done_d = (state_d == DONE);
        boot_err_d  = (state_d == ERR);
        // Released only once DONE has been held for a cycle, so the final
        // word write is already in memory when the CPU starts.
        cpu_rst_n_d = (state_q == DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            len_lo_q    <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'd0;
            cpu_rst_n_q <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            len_lo_q    <= len_lo_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;
    assign cpu_rst_n        = cpu_rst_n_q;
    assign boot_done        = boot_done_q;
    assign boot_err         = boot_err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_ctrl
// Directed bench for imem_boot_ctrl. Inputs change on the falling edge, the
// DUT samples on the rising edge, and outputs are observed on falling edges.
// -----------------------------------------------------------------------------
module tb_imem_boot_ctrl;
    import boot_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_rst_n;
    logic        boot_done;
    logic        boot_err;
    boot_state_t state;

    always #5 clk = ~clk;

    imem_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .start     (start),
        .cpu_rst_n (cpu_rst_n),
        .boot_done (boot_done),
        .boot_err  (boot_err),
        .state_o   (state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [31:0]       exp_q[$];      // expected write data, in order
    logic [31:0]       exp_a_q[$];    // expected write addresses, in order
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] got_addr[$];

    int   cyc          = 0;
    int   last_wr_cyc  = -1;
    int   rise_cyc     = -1;
    int   double_pulse = 0;
    logic prev_wr      = 1'b0;
    logic prev_cpu     = 1'b0;

    // Write-port monitor: logs each write, flags multi-cycle strobes and
    // records the cycle the CPU reset is released.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.imem_wr_en === 1'b1) begin
            got_data.push_back(bus.imem_wr_data);
            got_addr.push_back(bus.imem_wr_addr);
            last_wr_cyc = cyc;
            if (prev_wr) double_pulse = double_pulse + 1;
        end
        if (cpu_rst_n === 1'b1 && !prev_cpu) rise_cyc = cyc;
        prev_wr  = (bus.imem_wr_en === 1'b1);
        prev_cpu = (cpu_rst_n === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_spaced(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic send_b2b(input logic [7:0] bytes[$]);
        @(negedge clk);
        foreach (bytes[i]) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = bytes[i];
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_addr.delete();
        exp_q.delete();
        exp_a_q.delete();
        double_pulse = 0;
        last_wr_cyc  = -1;
        rise_cyc     = -1;
    endtask

    // Compare the logged writes with the expected queues.
    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(got_data.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check({tag, "_addr"}, (i < got_addr.size()) ? 32'(got_addr[i]) : 32'hxxxx_xxxx, exp_a_q[i]);
            check({tag, "_data"}, (i < got_data.size()) ? got_data[i] : 32'hxxxx_xxxx, exp_q[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] frame2[$];
    logic [7:0] frame1[$];
    logic [7:0] tmp[$];

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Two-word image; XOR of its payload is 93^13^01^10 = 0x91.
        frame2 = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                   8'h13, 8'h01, 8'h10, 8'h00};
        // One-word image; XOR of its payload is 78^56^34^12 = 0x08.
        frame1 = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef BOOT_CHECKSUM_EN
        frame2.push_back(8'h91);
        frame1.push_back(8'h08);
`endif

        // Reset values
        idle(3);
        check("rst_state",     32'(state), 32'(IDLE));
        check("rst_wr_en",     32'(bus.imem_wr_en), 32'd0);
        check("rst_wr_addr",   32'(bus.imem_wr_addr), 32'd0);
        check("rst_wr_data",   bus.imem_wr_data, 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_done",      32'(boot_done), 32'd0);
        check("rst_err",       32'(boot_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Noise bytes in IDLE
        clear_mon();
        send_spaced('{8'h00, 8'hFF});
        idle(2);
        check("noise_state", 32'(state), 32'(IDLE));
        check_writes("noise");

        // Two-word frame, spaced bytes
        clear_mon();
        exp_q   = '{32'h0000_0093, 32'h0010_0113};
        exp_a_q = '{32'd0, 32'd1};
        send_spaced(frame2);
        idle(4);
        check_writes("spaced");
        check("spaced_done",  32'(boot_done), 32'd1);
        check("spaced_err",   32'(boot_err), 32'd0);
        check("spaced_cpu",   32'(cpu_rst_n), 32'd1);
        check("spaced_state", 32'(state), 32'(DONE));
        check("spaced_pulse", 32'(double_pulse), 32'd0);
`ifndef BOOT_CHECKSUM_EN
        check("spaced_rise_after_wr", 32'(rise_cyc), 32'(last_wr_cyc + 1));
`else
        check("spaced_rise_after_wr", 32'(rise_cyc > last_wr_cyc), 32'd1);
`endif

        // Bytes in DONE are ignored
        clear_mon();
        send_spaced('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        idle(2);
        check("done_ignore_state", 32'(state), 32'(DONE));
        check_writes("done_ignore");

        // start re-arms
        pulse_start();
        check("start_state", 32'(state), 32'(IDLE));
        check("start_done",  32'(boot_done), 32'd0);
        check("start_cpu",   32'(cpu_rst_n), 32'd0);

        // Same frame, back-to-back bytes
        clear_mon();
        exp_q   = '{32'h0000_0093, 32'h0010_0113};
        exp_a_q = '{32'd0, 32'd1};
        send_b2b(frame2);
        idle(4);
        check_writes("b2b");
        check("b2b_done",  32'(boot_done), 32'd1);
        check("b2b_cpu",   32'(cpu_rst_n), 32'd1);
        check("b2b_pulse", 32'(double_pulse), 32'd0);
`ifndef BOOT_CHECKSUM_EN
        check("b2b_rise_after_wr", 32'(rise_cyc), 32'(last_wr_cyc + 1));
`endif

        // start and sync byte in the same cycle: the byte is lost
        clear_mon();
        @(negedge clk);
        start        = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        @(negedge clk);
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        send_spaced('{8'h01, 8'h00});
        idle(2);
        check("start_rx_state", 32'(state), 32'(IDLE));
        check("start_rx_done",  32'(boot_done), 32'd0);

        // Length 0x0401 > DEPTH
        send_spaced('{8'hA5, 8'h01, 8'h04});
        idle(1);
        check("len_big_state", 32'(state), 32'(ERR));
        check("len_big_err",   32'(boot_err), 32'd1);
        check("len_big_cpu",   32'(cpu_rst_n), 32'd0);
        send_spaced('{8'h11, 8'h22, 8'h33, 8'h44});
        idle(2);
        check("err_ignore_state", 32'(state), 32'(ERR));
        check("err_ignore_cpu",   32'(cpu_rst_n), 32'd0);
        check_writes("len_big");

        // Length exactly DEPTH is accepted, then reset mid-word
        pulse_start();
        check("err_start_err", 32'(boot_err), 32'd0);
        send_spaced('{8'hA5, 8'h00, 8'h04});
        check("len_depth_state", 32'(state), 32'(DATA));
        send_spaced('{8'h11, 8'h22});
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(state), 32'(IDLE));
        check("midrst_cpu",   32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check_writes("midrst");

        // Full reload from address 0
        clear_mon();
        exp_q   = '{32'h1234_5678};
        exp_a_q = '{32'd0};
        send_spaced(frame1);
        idle(4);
        check_writes("reload");
        check("reload_done", 32'(boot_done), 32'd1);
        check("reload_cpu",  32'(cpu_rst_n), 32'd1);

`ifdef BOOT_CHECKSUM_EN
        // Checksum off by one
        pulse_start();
        clear_mon();
        tmp = frame2;
        tmp[tmp.size()-1] = 8'h92;
        send_spaced(tmp);
        idle(3);
        check("csum_bad_err",  32'(boot_err), 32'd1);
        check("csum_bad_done", 32'(boot_done), 32'd0);
        check("csum_bad_cpu",  32'(cpu_rst_n), 32'd0);
        pulse_start();
        send_spaced(frame2);
        idle(3);
        check("csum_good_done", 32'(boot_done), 32'd1);
        check("csum_good_cpu",  32'(cpu_rst_n), 32'd1);
`endif

        // Zero-length image
        pulse_start();
        clear_mon();
        tmp = '{8'hA5, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        tmp.push_back(8'h00);
`endif
        send_spaced(tmp);
        idle(3);
        check("len0_done", 32'(boot_done), 32'd1);
        check("len0_cpu",  32'(cpu_rst_n), 32'd1);
        check_writes("len0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
